bitstream_scheduler: RTL and testbench

BITSTREAM_SCHEDULER -- requirements
Module: bitstream_scheduler

---
 rtl/bitstream_scheduler_pkg.sv | 37 +++
 rtl/bitstream_scheduler_if.sv | 34 +++
 rtl/bitstream_out_reg.sv | 49 ++++
 rtl/bitstream_scheduler.sv | 169 ++++++++++++++++
 tb/tb_bitstream_scheduler.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bitstream_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// bitstream_scheduler_pkg
// Shared definitions for the bitstream scheduler: scheduler states, source slot
// indices, data widths, the default per-beat bit limit and the size clamp
// helper used by the output register.
// -----------------------------------------------------------------------------
package bitstream_scheduler_pkg;

  localparam int NUM_SRC          = 3;
  localparam int DATA_W           = 64;
  localparam int MAX_BITS_DEFAULT = 64;

  // Source slot indices into the src_* vectors
  localparam int SRC_HDR   = 0;
  localparam int SRC_QMAT  = 1;
  localparam int SRC_SLICE = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_QMAT   = 3'd2,
    ST_SLICE  = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Limits a beat's bit count to the largest legal size
  function automatic logic [DATA_W-1:0] clamp_size(input logic [DATA_W-1:0] size,
                                                   input logic [DATA_W-1:0] max_bits);
    if (size > max_bits) begin
      return max_bits;
    end else begin
      return size;
    end
  endfunction

endpackage

// File: rtl/bitstream_scheduler_if.sv
// -----------------------------------------------------------------------------
// bitstream_scheduler_if
// Bundles the three beat sources and the bit-writer output handshake.
//   src_valid/src_val/src_size/src_last : per-source beats (0=hdr,1=qmat,2=slice)
//   src_ready                           : per-source accept
//   output_enable/val/size_of_bit/flush_bit : output beat toward the bit writer
//   wr_ready                            : bit writer accepts the output beat
// modport master : the scheduler side; modport slave : sources + bit writer.
// -----------------------------------------------------------------------------
interface bitstream_scheduler_if;
  import bitstream_scheduler_pkg::*;

  logic [NUM_SRC-1:0]             src_valid;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_val;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_size;
  logic [NUM_SRC-1:0]             src_last;
  logic [NUM_SRC-1:0]             src_ready;
  logic                           wr_ready;
  logic                           output_enable;
  logic [DATA_W-1:0]              val;
  logic [DATA_W-1:0]              size_of_bit;
  logic                           flush_bit;

  modport master (
    input  src_valid, src_val, src_size, src_last, wr_ready,
    output src_ready, output_enable, val, size_of_bit, flush_bit
  );

  modport slave (
    output src_valid, src_val, src_size, src_last, wr_ready,
    input  src_ready, output_enable, val, size_of_bit, flush_bit
  );

endinterface

// File: rtl/bitstream_out_reg.sv
// -----------------------------------------------------------------------------
// bitstream_out_reg
// Single-entry output register. Loads a beat when load is high, clamping its
// size to MAX_BITS; holds the beat unchanged while the writer stalls.
//   clock, reset      : clock and synchronous active-high reset
//   load              : capture in_val/in_size/in_flush (only when can_load)
//   wr_ready          : writer accepts the current beat
//   can_load          : register empty or being drained this cycle
//   output_enable/val/size_of_bit/flush_bit : registered output beat
// -----------------------------------------------------------------------------
module bitstream_out_reg
  import bitstream_scheduler_pkg::*;
#(
  parameter int MAX_BITS = MAX_BITS_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] in_val,
  input  logic [DATA_W-1:0] in_size,
  input  logic              in_flush,
  input  logic              wr_ready,
  output logic              can_load,
  output logic              output_enable,
  output logic [DATA_W-1:0] val,
  output logic [DATA_W-1:0] size_of_bit,
  output logic              flush_bit
);

  assign can_load = ~output_enable | wr_ready;

  // Output beat register: load, drain on consume, otherwise hold
  always_ff @(posedge clock) begin
    if (reset) begin
      output_enable <= 1'b0;
      val           <= '0;
      size_of_bit   <= '0;
      flush_bit     <= 1'b0;
    end else if (load) begin
      output_enable <= 1'b1;
      val           <= in_val;
      size_of_bit   <= clamp_size(in_size, DATA_W'(MAX_BITS));
      flush_bit     <= in_flush;
    end else if (output_enable && wr_ready) begin
      output_enable <= 1'b0;
    end
  end

endmodule

// File: rtl/bitstream_scheduler.sv
// -----------------------------------------------------------------------------
// bitstream_scheduler
// Sequences one frame as header -> (optional) quant matrix -> slice data ->
// byte-align flush beat, forwarding one source at a time to the bit writer.
//   clock, reset  : clock and synchronous active-high reset
//   frame_start   : starts a frame when idle
//   qmat_enable   : captured at frame start; 0 skips the quant-matrix slot
//   bus           : sources and bit-writer handshake (master side)
//   busy          : frame in progress
//   frame_done    : one-cycle pulse after the flush beat is taken
//   frame_bits    : saturating payload bit count of the current/last frame
//   size_err      : sticky, a beat exceeded MAX_BITS
// -----------------------------------------------------------------------------
module bitstream_scheduler
  import bitstream_scheduler_pkg::*;
#(
  parameter int MAX_BITS = MAX_BITS_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  qmat_enable,
  bitstream_scheduler_if.master bus,
  output logic                  busy,
  output logic                  frame_done,
  output logic [31:0]           frame_bits,
  output logic                  size_err
);

  state_t             state_r, state_s;
  logic               qmat_en_r;
  logic [1:0]         slot_s;
  logic               slot_active_s;
  logic               can_load_s;
  logic               accept_s;
  logic               load_flush_s;
  logic               flush_hs_s;
  logic [DATA_W-1:0]  beat_val_s;
  logic [DATA_W-1:0]  beat_size_s;
  logic               beat_flush_s;
  logic [DATA_W-1:0]  clamped_s;
  logic [DATA_W-1:0]  bits_sum_s;
  logic [31:0]        bits_next_s;

  // Active source slot decode from the current state
  always_comb begin
    slot_s        = 2'(SRC_HDR);
    slot_active_s = 1'b0;
    case (state_r)
      ST_HEADER: begin slot_s = 2'(SRC_HDR);   slot_active_s = 1'b1; end
      ST_QMAT:   begin slot_s = 2'(SRC_QMAT);  slot_active_s = 1'b1; end
      ST_SLICE:  begin slot_s = 2'(SRC_SLICE); slot_active_s = 1'b1; end
      default:   begin slot_s = 2'(SRC_HDR);   slot_active_s = 1'b0; end
    endcase
  end

  assign accept_s  = slot_active_s & bus.src_valid[slot_s] & can_load_s;
  assign clamped_s = clamp_size(bus.src_size[slot_s], DATA_W'(MAX_BITS));

  // Ready goes only to the active slot and only when the output register can take a beat
  always_comb begin
    bus.src_ready = '0;
    if (slot_active_s) begin
      bus.src_ready[slot_s] = can_load_s;
    end else begin
      bus.src_ready = '0;
    end
  end

  // Next-state logic and flush-beat load
  always_comb begin
    state_s      = state_r;
    load_flush_s = 1'b0;
    flush_hs_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (frame_start) state_s = ST_HEADER;
        else             state_s = ST_IDLE;
      end
      ST_HEADER: begin
        if (accept_s && bus.src_last[slot_s]) state_s = qmat_en_r ? ST_QMAT : ST_SLICE;
        else                                  state_s = ST_HEADER;
      end
      ST_QMAT: begin
        if (accept_s && bus.src_last[slot_s]) state_s = ST_SLICE;
        else                                  state_s = ST_QMAT;
      end
      ST_SLICE: begin
        if (accept_s && bus.src_last[slot_s]) state_s = ST_FLUSH;
        else                                  state_s = ST_SLICE;
      end
      ST_FLUSH: begin
        // Once loaded, the flush beat sits in the register until taken, so
        // can_load stays low and it is never loaded twice.
        flush_hs_s = bus.output_enable & bus.flush_bit & bus.wr_ready;
        if (flush_hs_s) begin
          state_s = ST_DONE;
        end else begin
          state_s      = ST_FLUSH;
          load_flush_s = can_load_s;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Beat presented to the output register: source data or the flush marker
  always_comb begin
    if (load_flush_s) begin
      beat_val_s   = '0;
      beat_size_s  = '0;
      beat_flush_s = 1'b1;
    end else begin
      beat_val_s   = bus.src_val[slot_s];
      beat_size_s  = bus.src_size[slot_s];
      beat_flush_s = 1'b0;
    end
  end

  // Saturating frame bit count update
  always_comb begin
    bits_sum_s = DATA_W'(frame_bits) + clamped_s;
    if (bits_sum_s[DATA_W-1:32] != '0) bits_next_s = 32'hFFFF_FFFF;
    else                               bits_next_s = bits_sum_s[31:0];
  end

  // State register, frame status and sticky size error
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      qmat_en_r  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_bits <= 32'd0;
      size_err   <= 1'b0;
    end else begin
      state_r    <= state_s;
      frame_done <= flush_hs_s;
      if (state_r == ST_IDLE && frame_start) begin
        qmat_en_r  <= qmat_enable;
        busy       <= 1'b1;
        frame_bits <= 32'd0;
      end else if (state_r == ST_DONE) begin
        busy <= 1'b0;
      end
      if (accept_s) begin
        frame_bits <= bits_next_s;
        if (bus.src_size[slot_s] > DATA_W'(MAX_BITS)) size_err <= 1'b1;
      end
    end
  end

  bitstream_out_reg #(.MAX_BITS(MAX_BITS)) u_out_reg (
    .clock         (clock),
    .reset         (reset),
    .load          (accept_s | load_flush_s),
    .in_val        (beat_val_s),
    .in_size       (beat_size_s),
    .in_flush      (beat_flush_s),
    .wr_ready      (bus.wr_ready),
    .can_load      (can_load_s),
    .output_enable (bus.output_enable),
    .val           (bus.val),
    .size_of_bit   (bus.size_of_bit),
    .flush_bit     (bus.flush_bit)
  );

endmodule

// File: tb/tb_bitstream_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bitstream_scheduler
// Scoreboard bench: source beats are queued per source, accepted beats are
// pushed as expected output beats, and every output beat on the bus is
// compared against the scoreboard head. A small phase model predicts
// src_ready, busy, frame_done, frame_bits and size_err each cycle.
// -----------------------------------------------------------------------------
module tb_bitstream_scheduler;
  import bitstream_scheduler_pkg::*;

  typedef struct {
    logic [63:0] val;
    logic [63:0] size;
    logic        last;
  } beat_t;

  typedef struct {
    logic [63:0] val;
    logic [63:0] size;
    logic        flush;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        qmat_enable;
  logic        busy;
  logic        frame_done;
  logic [31:0] frame_bits;
  logic        size_err;

  bitstream_scheduler_if bus();

  bitstream_scheduler #(.MAX_BITS(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .frame_start (frame_start),
    .qmat_enable (qmat_enable),
    .bus         (bus.master),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_bits  (frame_bits),
    .size_err    (size_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  beat_t src_q[3][$];
  exp_t  sb[$];

  // Model state
  int          m_phase = 0;   // 0 idle,1 hdr,2 qmat,3 slice,4 flush,5 done
  logic        m_busy = 1'b0;
  logic        m_fd = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] m_bits = 32'd0;
  logic        m_qen = 1'b0;
  logic        flush_loaded = 1'b0;
  logic        post_rst = 1'b0;

  // Per-frame stimulus control
  int cyc = 0;
  int fs_extra = -1;
  int rst_cycle = -1;
  int stall_from = 0;
  int stall_len = 0;
  bit rand_wr = 1'b0;
  bit frame_complete = 1'b0;

  function automatic logic [63:0] exp_size(input logic [63:0] s);
    return (s > 64'd64) ? 64'd64 : s;
  endfunction

  task automatic add_beats(input int src, input int n, input logic [63:0] size);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.val  = {$urandom, $urandom};
      b.size = size;
      b.last = (k == n - 1);
      src_q[src].push_back(b);
    end
  endtask

  task automatic step();
    logic [2:0]  exp_ready;
    logic        can_load;
    int          next_phase;
    logic        next_fd;
    logic [32:0] t;
    exp_t        e;
    beat_t       b;

    @(negedge clock);
    reset       = (cyc == rst_cycle);
    frame_start = (cyc == 0) || (cyc == fs_extra);
    if (rand_wr) bus.wr_ready = ($urandom_range(0, 3) != 0);
    else         bus.wr_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
    for (int i = 0; i < 3; i++) begin
      if (src_q[i].size() > 0) begin
        bus.src_valid[i] = 1'b1;
        bus.src_val[i]   = src_q[i][0].val;
        bus.src_size[i]  = src_q[i][0].size;
        bus.src_last[i]  = src_q[i][0].last;
      end else begin
        bus.src_valid[i] = 1'b0;
        bus.src_val[i]   = 64'd0;
        bus.src_size[i]  = 64'd0;
        bus.src_last[i]  = 1'b0;
      end
    end
    #1;

    if (post_rst) begin
      check("rst_val", bus.val, 64'd0);
      check("rst_size", bus.size_of_bit, 64'd0);
      check("rst_flush", bus.flush_bit, 1'b0);
      post_rst = 1'b0;
    end

    check("output_enable", bus.output_enable, sb.size() != 0);
    if (sb.size() != 0) begin
      check("beat_val", bus.val, sb[0].val);
      check("beat_size", bus.size_of_bit, sb[0].size);
      check("beat_flush", bus.flush_bit, sb[0].flush);
    end
    can_load  = (sb.size() == 0) || bus.wr_ready;
    exp_ready = 3'b000;
    if (m_phase >= 1 && m_phase <= 3 && can_load) exp_ready[m_phase-1] = 1'b1;
    check("src_ready", bus.src_ready, exp_ready);
    check("busy", busy, m_busy);
    check("frame_done", frame_done, m_fd);
    check("frame_bits", frame_bits, m_bits);
    check("size_err", size_err, m_err);

    if (reset) begin
      sb.delete();
      for (int i = 0; i < 3; i++) src_q[i].delete();
      m_phase = 0; m_busy = 1'b0; m_fd = 1'b0; m_bits = 32'd0; m_err = 1'b0;
      flush_loaded = 1'b0; post_rst = 1'b1; frame_complete = 1'b1;
      cyc++;
      return;
    end

    next_phase = m_phase;
    next_fd    = 1'b0;
    if (sb.size() != 0 && bus.wr_ready) begin
      e = sb.pop_front();
      if (e.flush) begin
        next_phase = 5;
        next_fd    = 1'b1;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (bus.src_valid[i] && exp_ready[i]) begin
        b = src_q[i].pop_front();
        sb.push_back('{b.val, exp_size(b.size), 1'b0});
        t = {1'b0, m_bits} + 33'(exp_size(b.size));
        m_bits = t[32] ? 32'hFFFF_FFFF : t[31:0];
        if (b.size > 64'd64) m_err = 1'b1;
        if (b.last) begin
          if (m_phase == 1)      next_phase = m_qen ? 2 : 3;
          else if (m_phase == 2) next_phase = 3;
          else                   next_phase = 4;
        end
      end
    end
    if (m_phase == 4 && !flush_loaded && can_load) begin
      sb.push_back('{64'd0, 64'd0, 1'b1});
      flush_loaded = 1'b1;
    end
    if (m_phase == 5) begin
      next_phase     = 0;
      m_busy         = 1'b0;
      frame_complete = 1'b1;
    end
    if (m_phase == 0 && frame_start) begin
      next_phase   = 1;
      m_busy       = 1'b1;
      m_bits       = 32'd0;
      m_qen        = qmat_enable;
      flush_loaded = 1'b0;
    end
    m_fd    = next_fd;
    m_phase = next_phase;
    cyc++;
  endtask

  task automatic run_frame(input logic qen, input longint exp_total);
    qmat_enable    = qen;
    cyc            = 0;
    frame_complete = 1'b0;
    while (!frame_complete && cyc < 3000) step();
    check("frame_complete", frame_complete, 1'b1);
    repeat (2) step();
    if (exp_total >= 0) check("frame_bits_total", frame_bits, 64'(exp_total));
    check("sb_empty", sb.size(), 0);
    for (int i = 0; i < 3; i++) src_q[i].delete();
    fs_extra   = -1;
    rst_cycle  = -1;
    stall_len  = 0;
    rand_wr    = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    frame_start   = 1'b0;
    qmat_enable   = 1'b0;
    bus.wr_ready  = 1'b1;
    bus.src_valid = '0;
    bus.src_val   = '0;
    bus.src_size  = '0;
    bus.src_last  = '0;
    repeat (3) @(negedge clock);
    #1;
    check("init_oe", bus.output_enable, 1'b0);
    check("init_val", bus.val, 64'd0);
    check("init_size", bus.size_of_bit, 64'd0);
    check("init_flush", bus.flush_bit, 1'b0);
    check("init_busy", busy, 1'b0);
    check("init_done", frame_done, 1'b0);
    check("init_bits", frame_bits, 32'd0);
    check("init_err", size_err, 1'b0);
    check("init_ready", bus.src_ready, 3'b000);

    // Full frame with quant matrix: 133 beats then flush
    add_beats(SRC_HDR, 2, 64'd8);
    add_beats(SRC_QMAT, 128, 64'd8);
    add_beats(SRC_SLICE, 3, 64'd16);
    run_frame(1'b1, 1088);

    // Quant matrix skipped while its source stays valid
    add_beats(SRC_HDR, 2, 64'd8);
    add_beats(SRC_QMAT, 4, 64'd8);
    add_beats(SRC_SLICE, 3, 64'd16);
    run_frame(1'b0, 64);

    // Writer stall mid-slice
    add_beats(SRC_HDR, 1, 64'd8);
    add_beats(SRC_SLICE, 8, 64'd32);
    stall_from = 4;
    stall_len  = 5;
    run_frame(1'b0, 264);

    // Oversize header beat clamps and sets the sticky error
    add_beats(SRC_HDR, 1, 64'd100);
    add_beats(SRC_SLICE, 2, 64'd16);
    run_frame(1'b0, 96);
    check("size_err_set", size_err, 1'b1);

    // Next frame: error stays set, frame_start during slice is ignored
    add_beats(SRC_HDR, 1, 64'd8);
    add_beats(SRC_QMAT, 2, 64'd8);
    add_beats(SRC_SLICE, 4, 64'd16);
    fs_extra = 5;
    run_frame(1'b1, 88);
    check("size_err_sticky", size_err, 1'b1);

    // Reset during the quant-matrix slot abandons the frame
    add_beats(SRC_HDR, 1, 64'd8);
    add_beats(SRC_QMAT, 10, 64'd8);
    add_beats(SRC_SLICE, 2, 64'd16);
    rst_cycle = 6;
    run_frame(1'b1, -1);
    check("rst_bits", frame_bits, 32'd0);
    check("rst_err", size_err, 1'b0);

    // Zero-size beats with random writer backpressure
    add_beats(SRC_HDR, 1, 64'd0);
    add_beats(SRC_SLICE, 1, 64'd5);
    add_beats(SRC_SLICE, 2, 64'd0);
    rand_wr = 1'b1;
    run_frame(1'b0, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
